// File: rtl/bist_sequencer_if.sv
// Bus bundle between the test-access controller (master) and the BIST sequencer (slave).
// Signals:
//   bist_start, abort, cfg_n, cfg_m, chan_en, chan_fail : controller/checkers -> sequencer
//   mode, init, running, finish, bist_end              : sequencer phase indications
//   chan_sel, fail_vec, pass, aborted                   : sequencer channel select and verdict
interface bist_sequencer_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned N_WIDTH  = 8,
  parameter int unsigned M_WIDTH  = 8
);
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                bist_start;
  logic                abort;
  logic [N_WIDTH-1:0]  cfg_n;
  logic [M_WIDTH-1:0]  cfg_m;
  logic [CHANNELS-1:0] chan_en;
  logic [CHANNELS-1:0] chan_fail;

  logic                mode;
  logic                init;
  logic                running;
  logic                finish;
  logic                bist_end;
  logic [CH_W-1:0]     chan_sel;
  logic [CHANNELS-1:0] fail_vec;
  logic                pass;
  logic                aborted;

  modport master (
    output bist_start, abort, cfg_n, cfg_m, chan_en, chan_fail,
    input  mode, init, running, finish, bist_end, chan_sel, fail_vec, pass, aborted
  );

  modport slave (
    input  bist_start, abort, cfg_n, cfg_m, chan_en, chan_fail,
    output mode, init, running, finish, bist_end, chan_sel, fail_vec, pass, aborted
  );
endinterface

// File: rtl/bist_sequencer.sv
// Multi-channel BIST sequencer. On a rising edge of bist_start it walks every enabled
// channel in ascending order: one INIT cycle, then cfg_m iterations of (cfg_n RUN cycles
// + one CHECK cycle). Per-channel fail flags are collected, finish pulses, and DONE holds
// the pass/fail verdict until the next start edge.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : bist_sequencer_if.slave (start/abort/config/fail inputs, phase and verdict outputs)
module bist_sequencer #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned N_WIDTH  = 8,
  parameter int unsigned M_WIDTH  = 8
) (
  input  logic            clock,
  input  logic            reset,
  bist_sequencer_if.slave bus
);
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_RUN    = 3'd2,
    S_CHECK  = 3'd3,
    S_FINISH = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e              state_q,      state_d;
  logic                prev_start_q, prev_start_d;
  logic [N_WIDTH-1:0]  cfg_n_q,      cfg_n_d;
  logic [M_WIDTH-1:0]  cfg_m_q,      cfg_m_d;
  logic [CHANNELS-1:0] mask_q,       mask_d;
  logic [N_WIDTH-1:0]  run_cnt_q,    run_cnt_d;
  logic [M_WIDTH-1:0]  iter_cnt_q,   iter_cnt_d;
  logic [CH_W-1:0]     chan_sel_q,   chan_sel_d;
  logic [CHANNELS-1:0] fail_vec_q,   fail_vec_d;
  logic                aborted_q,    aborted_d;

  logic                mode_q,     mode_d;
  logic                init_q,     init_d;
  logic                running_q,  running_d;
  logic                finish_q,   finish_d;
  logic                bist_end_q, bist_end_d;
  logic                pass_q,     pass_d;

  logic                start_edge_c;
  logic [N_WIDTH-1:0]  n_eff_c;
  logic [M_WIDTH-1:0]  m_eff_c;
  logic [M_WIDTH-1:0]  iter_inc_c;
  logic [CH_W-1:0]     first_ch_c;
  logic [CH_W-1:0]     next_ch_c;
  logic                next_found_c;
  logic [CHANNELS-1:0] sel_mask_c;

  // Lowest enabled channel of the incoming mask, and lowest latched channel above chan_sel.
  // Scanning downward lets the last hit be the lowest match.
  always_comb begin
    first_ch_c   = '0;
    next_ch_c    = '0;
    next_found_c = 1'b0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (bus.chan_en[i]) begin
        first_ch_c = CH_W'(i);
      end
      if (mask_q[i] && (i > int'(chan_sel_q))) begin
        next_ch_c    = CH_W'(i);
        next_found_c = 1'b1;
      end
    end
  end

  // Next-state, counter, verdict and output computation.
  always_comb begin
    state_d      = state_q;
    prev_start_d = bus.bist_start;
    cfg_n_d      = cfg_n_q;
    cfg_m_d      = cfg_m_q;
    mask_d       = mask_q;
    run_cnt_d    = run_cnt_q;
    iter_cnt_d   = iter_cnt_q;
    chan_sel_d   = chan_sel_q;
    fail_vec_d   = fail_vec_q;
    aborted_d    = aborted_q;

    start_edge_c = bus.bist_start & ~prev_start_q;
    // Zero configs behave as one so every enabled channel gets at least one RUN and CHECK.
    n_eff_c      = (cfg_n_q == '0) ? N_WIDTH'(1) : cfg_n_q;
    m_eff_c      = (cfg_m_q == '0) ? M_WIDTH'(1) : cfg_m_q;
    iter_inc_c   = iter_cnt_q + M_WIDTH'(1);
    sel_mask_c   = CHANNELS'(1) << chan_sel_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // Abort is ignored here; a start edge always relaunches.
        if (start_edge_c) begin
          cfg_n_d    = bus.cfg_n;
          cfg_m_d    = bus.cfg_m;
          mask_d     = bus.chan_en;
          fail_vec_d = '0;
          aborted_d  = 1'b0;
          run_cnt_d  = '0;
          iter_cnt_d = '0;
          if (bus.chan_en == '0) begin
            state_d = S_FINISH;
          end else begin
            state_d    = S_INIT;
            chan_sel_d = first_ch_c;
          end
        end
      end

      S_INIT: begin
        if (bus.abort) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else begin
          state_d    = S_RUN;
          run_cnt_d  = N_WIDTH'(1);
          iter_cnt_d = '0;
        end
      end

      // run_cnt holds the index (from 1) of the current RUN cycle; equality stop avoids wrap.
      S_RUN: begin
        if (bus.abort) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (run_cnt_q == n_eff_c) begin
          state_d = S_CHECK;
        end else begin
          run_cnt_d = run_cnt_q + N_WIDTH'(1);
        end
      end

      // A CHECK cut short by abort does not sample chan_fail.
      S_CHECK: begin
        if (bus.abort) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else begin
          fail_vec_d = fail_vec_q | (bus.chan_fail & sel_mask_c);
          iter_cnt_d = iter_inc_c;
          if (iter_inc_c != m_eff_c) begin
            state_d   = S_RUN;
            run_cnt_d = N_WIDTH'(1);
          end else if (next_found_c) begin
            state_d    = S_INIT;
            chan_sel_d = next_ch_c;
            run_cnt_d  = '0;
            iter_cnt_d = '0;
          end else begin
            state_d = S_FINISH;
          end
        end
      end

      S_FINISH: begin
        state_d = S_DONE;
        if (bus.abort) begin
          aborted_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs registered from the next state so they align with the state register.
    mode_d     = (state_d == S_RUN);
    init_d     = (state_d == S_INIT);
    running_d  = (state_d == S_RUN) || (state_d == S_CHECK);
    finish_d   = (state_d == S_FINISH);
    bist_end_d = (state_d == S_DONE);
    pass_d     = (state_d == S_DONE) && (fail_vec_d == '0) && !aborted_d;
  end

  // State and output registers; prev_start resets high so a held start does not launch.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      prev_start_q <= 1'b1;
      cfg_n_q      <= '0;
      cfg_m_q      <= '0;
      mask_q       <= '0;
      run_cnt_q    <= '0;
      iter_cnt_q   <= '0;
      chan_sel_q   <= '0;
      fail_vec_q   <= '0;
      aborted_q    <= 1'b0;
      mode_q       <= 1'b0;
      init_q       <= 1'b0;
      running_q    <= 1'b0;
      finish_q     <= 1'b0;
      bist_end_q   <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_start_q <= prev_start_d;
      cfg_n_q      <= cfg_n_d;
      cfg_m_q      <= cfg_m_d;
      mask_q       <= mask_d;
      run_cnt_q    <= run_cnt_d;
      iter_cnt_q   <= iter_cnt_d;
      chan_sel_q   <= chan_sel_d;
      fail_vec_q   <= fail_vec_d;
      aborted_q    <= aborted_d;
      mode_q       <= mode_d;
      init_q       <= init_d;
      running_q    <= running_d;
      finish_q     <= finish_d;
      bist_end_q   <= bist_end_d;
      pass_q       <= pass_d;
    end
  end

  assign bus.mode     = mode_q;
  assign bus.init     = init_q;
  assign bus.running  = running_q;
  assign bus.finish   = finish_q;
  assign bus.bist_end = bist_end_q;
  assign bus.chan_sel = chan_sel_q;
  assign bus.fail_vec = fail_vec_q;
  assign bus.pass     = pass_q;
  assign bus.aborted  = aborted_q;
endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench for bist_sequencer: a 4-channel / 8-bit instance and a 4-bit cfg_n instance.
module tb_bist_sequencer;
  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  // Status order: {mode, init, running, finish, bist_end, pass, aborted}
  localparam logic [6:0] ST_IDLE = 7'b0000000;
  localparam logic [6:0] ST_INIT = 7'b0100000;
  localparam logic [6:0] ST_RUN  = 7'b1010000;
  localparam logic [6:0] ST_CHK  = 7'b0010000;
  localparam logic [6:0] ST_FIN  = 7'b0001000;
  localparam logic [6:0] ST_DP   = 7'b0000110;
  localparam logic [6:0] ST_DF   = 7'b0000100;
  localparam logic [6:0] ST_DA   = 7'b0000101;

  bist_sequencer_if #(.CHANNELS(4), .N_WIDTH(8), .M_WIDTH(8)) bus ();
  bist_sequencer_if #(.CHANNELS(4), .N_WIDTH(4), .M_WIDTH(8)) bus6 ();

  bist_sequencer #(.CHANNELS(4), .N_WIDTH(8), .M_WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  bist_sequencer #(.CHANNELS(4), .N_WIDTH(4), .M_WIDTH(8)) dut6 (
    .clock (clock),
    .reset (reset),
    .bus   (bus6)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [6:0] st_main();
    return {bus.mode, bus.init, bus.running, bus.finish, bus.bist_end, bus.pass, bus.aborted};
  endfunction

  function automatic logic [6:0] st_six();
    return {bus6.mode, bus6.init, bus6.running, bus6.finish, bus6.bist_end, bus6.pass, bus6.aborted};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
    bus.chan_fail = '0;
  endtask

  // Guarantee a low cycle, then raise bist_start; the next step samples the edge.
  task automatic launch();
    bus.bist_start = 1'b0;
    step();
    bus.bist_start = 1'b1;
  endtask

  // Walk one channel: INIT, then m x (n RUN + CHECK). Optional fail injection at a CHECK,
  // chan_fail noise during RUN, and a start re-edge during the first RUN.
  task automatic chan_walk(input logic [1:0] sel, input int n, input int m, input int fail_it,
                           input logic [3:0] fail_val, input bit poke, input bit noise);
    step();
    chk("init_state", 32'(st_main()), 32'(ST_INIT));
    chk("init_sel", 32'(bus.chan_sel), 32'(sel));
    for (int it = 0; it < m; it++) begin
      for (int r = 0; r < n; r++) begin
        step();
        chk("run_state", 32'(st_main()), 32'(ST_RUN));
        if (noise) bus.chan_fail = 4'b1111;
        if (poke && it == 0 && r == 0) bus.bist_start = 1'b1;
      end
      step();
      chk("check_state", 32'(st_main()), 32'(ST_CHK));
      if (it == fail_it) bus.chan_fail = fail_val;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.bist_start = 1'b1;
    bus.abort      = 1'b0;
    bus.cfg_n      = '0;
    bus.cfg_m      = '0;
    bus.chan_en    = '0;
    bus.chan_fail  = '0;
    bus6.bist_start = 1'b0;
    bus6.abort      = 1'b0;
    bus6.cfg_n      = '0;
    bus6.cfg_m      = '0;
    bus6.chan_en    = '0;
    bus6.chan_fail  = '0;

    // T5a: start held high through reset release does not launch
    step(); step(); step();
    chk("reset_state", 32'(st_main()), 32'(ST_IDLE));
    chk("reset_sel", 32'(bus.chan_sel), 32'h0);
    chk("reset_failvec", 32'(bus.fail_vec), 32'h0);
    reset = 1'b0;
    step();
    chk("held_start_idle0", 32'(st_main()), 32'(ST_IDLE));
    step();
    chk("held_start_idle1", 32'(st_main()), 32'(ST_IDLE));

    // T1: two channels, mid-run config change and start re-edge have no effect
    bus.cfg_n = 8'd3; bus.cfg_m = 8'd2; bus.chan_en = 4'b0101;
    launch();
    chan_walk(2'd0, 3, 2, -1, 4'b0000, 1'b0, 1'b0);
    bus.cfg_n = 8'd1; bus.cfg_m = 8'd5; bus.chan_en = 4'b1111;
    bus.bist_start = 1'b0;
    chan_walk(2'd2, 3, 2, -1, 4'b0000, 1'b1, 1'b0);
    step();
    chk("t1_finish", 32'(st_main()), 32'(ST_FIN));
    step();
    chk("t1_done_pass", 32'(st_main()), 32'(ST_DP));
    chk("t1_failvec", 32'(bus.fail_vec), 32'h0);
    step();
    chk("t1_done_hold", 32'(st_main()), 32'(ST_DP));
    chk("t1_sel_hold", 32'(bus.chan_sel), 32'h2);

    // T2: chan_fail only sampled in CHECK and only for the selected channel
    bus.cfg_n = 8'd3; bus.cfg_m = 8'd2; bus.chan_en = 4'b0101;
    launch();
    chan_walk(2'd0, 3, 2, -1, 4'b0000, 1'b0, 1'b1);
    chk("t2_failvec_mid", 32'(bus.fail_vec), 32'h0);
    chan_walk(2'd2, 3, 2, 0, 4'b1111, 1'b0, 1'b1);
    step();
    chk("t2_finish", 32'(st_main()), 32'(ST_FIN));
    step();
    chk("t2_done_fail", 32'(st_main()), 32'(ST_DF));
    chk("t2_failvec", 32'(bus.fail_vec), 32'h4);

    // T3: zero configs behave as one; empty mask goes straight to FINISH
    bus.cfg_n = 8'd0; bus.cfg_m = 8'd0; bus.chan_en = 4'b1000;
    launch();
    chan_walk(2'd3, 1, 1, -1, 4'b0000, 1'b0, 1'b0);
    step();
    chk("t3_finish", 32'(st_main()), 32'(ST_FIN));
    step();
    chk("t3_done_pass", 32'(st_main()), 32'(ST_DP));
    chk("t3_failvec_cleared", 32'(bus.fail_vec), 32'h0);
    bus.chan_en = 4'b0000;
    launch();
    step();
    chk("t3_empty_finish", 32'(st_main()), 32'(ST_FIN));
    step();
    chk("t3_empty_done", 32'(st_main()), 32'(ST_DP));

    // T4: abort in RUN, ignored in DONE, start wins over abort, abort in CHECK skips sampling
    bus.cfg_n = 8'd3; bus.cfg_m = 8'd2; bus.chan_en = 4'b0101;
    launch();
    step();
    chk("t4_init", 32'(st_main()), 32'(ST_INIT));
    step();
    chk("t4_run1", 32'(st_main()), 32'(ST_RUN));
    step();
    chk("t4_run2", 32'(st_main()), 32'(ST_RUN));
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("t4_aborted", 32'(st_main()), 32'(ST_DA));
    step();
    chk("t4_aborted_hold", 32'(st_main()), 32'(ST_DA));
    bus.abort = 1'b1;
    step();
    chk("t4_abort_in_done", 32'(st_main()), 32'(ST_DA));
    bus.chan_en = 4'b0000;
    launch();
    step();
    bus.abort = 1'b0;
    chk("t4_start_wins", 32'(st_main()), 32'(ST_FIN));
    step();
    chk("t4_relaunch_done", 32'(st_main()), 32'(ST_DP));
    bus.cfg_n = 8'd1; bus.cfg_m = 8'd1; bus.chan_en = 4'b0001;
    launch();
    step();
    chk("t4b_init", 32'(st_main()), 32'(ST_INIT));
    step();
    chk("t4b_run", 32'(st_main()), 32'(ST_RUN));
    step();
    chk("t4b_check", 32'(st_main()), 32'(ST_CHK));
    bus.chan_fail = 4'b1111;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("t4b_aborted", 32'(st_main()), 32'(ST_DA));
    chk("t4b_failvec", 32'(bus.fail_vec), 32'h0);

    // T5b: reset in RUN clears everything next cycle
    bus.cfg_n = 8'd3; bus.cfg_m = 8'd2; bus.chan_en = 4'b0100;
    launch();
    step();
    chk("t5_init_sel", 32'(bus.chan_sel), 32'h2);
    step();
    chk("t5_run", 32'(st_main()), 32'(ST_RUN));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_reset_state", 32'(st_main()), 32'(ST_IDLE));
    chk("t5_reset_sel", 32'(bus.chan_sel), 32'h0);
    step();
    chk("t5_idle_after", 32'(st_main()), 32'(ST_IDLE));

    // T6: 4-bit cfg_n at its maximum runs 15 RUN cycles without wrapping
    bus6.cfg_n = 4'd15; bus6.cfg_m = 8'd1; bus6.chan_en = 4'b0010;
    step();
    bus6.bist_start = 1'b1;
    step();
    chk("t6_init", 32'(st_six()), 32'(ST_INIT));
    chk("t6_sel", 32'(bus6.chan_sel), 32'h1);
    for (int r = 0; r < 15; r++) begin
      step();
      chk("t6_run", 32'(st_six()), 32'(ST_RUN));
    end
    step();
    chk("t6_check", 32'(st_six()), 32'(ST_CHK));
    step();
    chk("t6_finish", 32'(st_six()), 32'(ST_FIN));
    step();
    chk("t6_done", 32'(st_six()), 32'(ST_DP));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
